uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl_if.sv | 39 +++
 rtl/uart_tx_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_ctrl_if
// Description : Parallel-side request bundle and serial line of uart_tx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        output STOP2,
        input  TX_OUT,
        input  busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        input  STOP2,
        output TX_OUT,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART frame serializer, one line bit per CLK, optional parity
//               and one/two stop bits. Define UART_TX_BACK2BACK_EN to allow a
//               new frame to start right after the final stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    uart_tx_ctrl_if.slave      bus
);
    localparam int c_CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        c_IDLE   = 3'd0,
        c_START  = 3'd1,
        c_DATA   = 3'd2,
        c_PARITY = 3'd3,
        c_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stop2;
    logic                  r_stop_second;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_tx;
    logic                  r_busy;

    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_last_bit;
    logic                  w_parity;

    assign w_cnt_nxt  = r_cnt + c_CNT_W'(1);
    assign w_last_bit = (r_cnt == c_CNT_W'(DATA_WIDTH - 1));
    assign w_parity   = (^r_data) ^ r_par_typ;

    // TX_OUT is registered: the value assigned at an edge is the bit of the state being entered.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state       <= c_IDLE;
            r_data        <= '0;
            r_par_en      <= 1'b0;
            r_par_typ     <= 1'b0;
            r_stop2       <= 1'b0;
            r_stop_second <= 1'b0;
            r_cnt         <= '0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (bus.Data_Valid) begin
                        r_data    <= bus.P_DATA;
                        r_par_en  <= bus.PAR_EN;
                        r_par_typ <= bus.PAR_TYP;
                        r_stop2   <= bus.STOP2;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_START;
                    end
                end

                c_START: begin
                    r_cnt   <= '0;
                    r_tx    <= r_data[0];
                    r_state <= c_DATA;
                end

                c_DATA: begin
                    if (w_last_bit) begin
                        if (r_par_en) begin
                            r_tx    <= w_parity;
                            r_state <= c_PARITY;
                        end else begin
                            r_tx          <= 1'b1;
                            r_stop_second <= 1'b0;
                            r_state       <= c_STOP;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        r_tx  <= r_data[w_cnt_nxt];
                    end
                end

                c_PARITY: begin
                    r_tx          <= 1'b1;
                    r_stop_second <= 1'b0;
                    r_state       <= c_STOP;
                end

                c_STOP: begin
                    if (r_stop2 && !r_stop_second) begin
                        r_stop_second <= 1'b1;
                        r_tx          <= 1'b1;
                    end else begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
`ifdef UART_TX_BACK2BACK_EN
                        if (bus.Data_Valid) begin
                            r_data    <= bus.P_DATA;
                            r_par_en  <= bus.PAR_EN;
                            r_par_typ <= bus.PAR_TYP;
                            r_stop2   <= bus.STOP2;
                            r_tx      <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= c_START;
                        end
`endif
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.TX_OUT = r_tx;
    assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl (8, 5 and 9 bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;
    logic CLK;
    logic RST;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) if8 ();
    uart_tx_ctrl_if #(.DATA_WIDTH(5)) if5 ();
    uart_tx_ctrl_if #(.DATA_WIDTH(9)) if9 ();

    uart_tx_ctrl #(.DATA_WIDTH(8)) u_dut8 (.CLK(CLK), .RST(RST), .bus(if8));
    uart_tx_ctrl #(.DATA_WIDTH(5)) u_dut5 (.CLK(CLK), .RST(RST), .bus(if5));
    uart_tx_ctrl #(.DATA_WIDTH(9)) u_dut9 (.CLK(CLK), .RST(RST), .bus(if9));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: a frame is just a list of line bits queued at acceptance.
    bit q[$];
    bit m_tx   = 1'b1;
    bit m_busy = 1'b0;
    bit m_can;

    always @(posedge CLK) begin
        if (!RST) begin
            q.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else if (q.size() > 0) begin
            m_tx   = q.pop_front();
            m_busy = 1'b1;
        end else begin
            m_can = !m_busy;
`ifdef UART_TX_BACK2BACK_EN
            m_can = 1'b1;
`endif
            if (m_can && if8.Data_Valid) begin
                q.push_back(1'b0);
                for (int k = 0; k < 8; k++) q.push_back(if8.P_DATA[k]);
                if (if8.PAR_EN) q.push_back((^if8.P_DATA) ^ if8.PAR_TYP);
                q.push_back(1'b1);
                if (if8.STOP2) q.push_back(1'b1);
                m_tx   = q.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
        #1;
        chk("model_tx",   {31'd0, if8.TX_OUT}, {31'd0, m_tx});
        chk("model_busy", {31'd0, if8.busy},   {31'd0, m_busy});
    end

    task automatic wait_idle();
        if8.Data_Valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (!if8.busy) break;
        end
        chk("idle_timeout", {31'd0, if8.busy}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit pe, input bit pt, input bit s2,
                             input int n, input bit hold, input bit mutate,
                             output logic [15:0] tx, output logic [15:0] bz);
        @(negedge CLK);
        if8.P_DATA = d; if8.PAR_EN = pe; if8.PAR_TYP = pt; if8.STOP2 = s2;
        if8.Data_Valid = 1'b1;
        tx = '1; bz = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            tx[i] = if8.TX_OUT;
            bz[i] = if8.busy;
            if (i == 0) begin
                if (!hold) if8.Data_Valid = 1'b0;
                if (mutate) begin
                    if8.P_DATA  = ~d;
                    if8.PAR_TYP = ~pt;
                end
            end
        end
    endtask

    logic [15:0] tx, bz, t5, b5, t9, b9;

    initial begin
        RST = 1'b0;
        if8.P_DATA = '0; if8.Data_Valid = 1'b0; if8.PAR_EN = 1'b0; if8.PAR_TYP = 1'b0; if8.STOP2 = 1'b0;
        if5.P_DATA = '0; if5.Data_Valid = 1'b0; if5.PAR_EN = 1'b0; if5.PAR_TYP = 1'b0; if5.STOP2 = 1'b0;
        if9.P_DATA = '0; if9.Data_Valid = 1'b0; if9.PAR_EN = 1'b0; if9.PAR_TYP = 1'b0; if9.STOP2 = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_tx",   {31'd0, if8.TX_OUT}, 32'd1);
        chk("reset_busy", {31'd0, if8.busy},   32'd0);
        @(negedge CLK); RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("idle_tx",   {31'd0, if8.TX_OUT}, 32'd1);
        chk("idle_busy", {31'd0, if8.busy},   32'd0);

        // 0xA5, no parity, one stop
        run_frame(8'hA5, 0, 0, 0, 11, 0, 0, tx, bz);
        chk("a5_line", {21'd0, tx[10:0]}, {21'd0, 11'b11101001010});
        chk("a5_busy", {21'd0, bz[10:0]}, {21'd0, 11'b01111111111});
        wait_idle();

        // 0x07 even then odd parity
        run_frame(8'h07, 1, 0, 0, 12, 0, 0, tx, bz);
        chk("par_even", {31'd0, tx[9]}, 32'd1);
        chk("par_even_len", {20'd0, bz[11:0]}, {20'd0, 12'h7FF});
        wait_idle();
        run_frame(8'h07, 1, 1, 0, 12, 0, 0, tx, bz);
        chk("par_odd", {31'd0, tx[9]}, 32'd0);
        chk("par_odd_data", {24'd0, tx[8:1]}, 32'h07);
        wait_idle();

        // inputs changed after acceptance must not affect the frame
        run_frame(8'h00, 1, 0, 1, 13, 0, 1, tx, bz);
        chk("latch_bits", {22'd0, tx[9:0]}, 32'd0);
        chk("latch_stop", {30'd0, tx[11:10]}, 32'd3);
        chk("latch_len",  {19'd0, bz[12:0]}, {19'd0, 13'h0FFF});
        wait_idle();

        // request held high across frames
        run_frame(8'h3C, 0, 0, 0, 12, 1, 0, tx, bz);
        chk("hold_data", {24'd0, tx[8:1]}, 32'h3C);
`ifdef UART_TX_BACK2BACK_EN
        chk("b2b_busy",  {31'd0, bz[10]}, 32'd1);
        chk("b2b_start", {31'd0, tx[10]}, 32'd0);
`else
        chk("gap_busy",  {31'd0, bz[10]}, 32'd0);
        chk("gap_line",  {31'd0, tx[10]}, 32'd1);
        chk("gap_start", {31'd0, tx[11]}, 32'd0);
`endif
        wait_idle();

        // reset while the 4th data bit is due
        run_frame(8'h00, 0, 0, 0, 4, 0, 0, tx, bz);
        chk("pre_abort_line", {31'd0, tx[3]}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("abort_tx",   {31'd0, if8.TX_OUT}, 32'd1);
        chk("abort_busy", {31'd0, if8.busy},   32'd0);
        @(negedge CLK); RST = 1'b1;
        wait_idle();
        run_frame(8'h55, 0, 0, 0, 11, 0, 0, tx, bz);
        chk("post_abort_line", {21'd0, tx[10:0]}, {21'd0, 11'b11010101010});
        wait_idle();

        // 5- and 9-bit builds
        @(negedge CLK);
        if5.P_DATA = 5'h15;  if5.Data_Valid = 1'b1;
        if9.P_DATA = 9'h1AB; if9.Data_Valid = 1'b1;
        t5 = '1; b5 = '0; t9 = '1; b9 = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            t5[i] = if5.TX_OUT; b5[i] = if5.busy;
            t9[i] = if9.TX_OUT; b9[i] = if9.busy;
            if (i == 0) begin if5.Data_Valid = 1'b0; if9.Data_Valid = 1'b0; end
        end
        chk("w5_start", {31'd0, t5[0]}, 32'd0);
        chk("w5_data",  {27'd0, t5[5:1]}, 32'h15);
        chk("w5_busy",  {24'd0, b5[7:0]}, 32'h7F);
        chk("w9_start", {31'd0, t9[0]}, 32'd0);
        chk("w9_data",  {23'd0, t9[9:1]}, 32'h1AB);
        chk("w9_busy",  {20'd0, b9[11:0]}, 32'h7FF);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if8.P_DATA     = 8'($urandom);
            if8.PAR_EN     = 1'($urandom);
            if8.PAR_TYP    = 1'($urandom);
            if8.STOP2      = 1'($urandom);
            if8.Data_Valid = ($urandom_range(0, 3) != 0);
            RST            = ($urandom_range(0, 79) != 0);
        end
        @(negedge CLK); RST = 1'b1;
        wait_idle();
        repeat (2) @(posedge CLK);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
